axis_uart_tx_arb: RTL and testbench
===================================

AXIS_UART_TX_ARB -- requirements
Module: axis_uart_tx_arb

Interface
REQ-001 SHALL have parameter NUM_SRC, default 4, number of AXI-Stream requesters (2..8).
REQ-002 SHALL have parameter DATA_WIDTH, default 9, beat width, which matches the UART transmit stream.
REQ-003 SHALL have parameter ADD_HEADER, default 0; when 1, one header beat precedes every packet.
REQ-004 SHALL have parameter HEADER_BASE, default 8'hA0, upper bits of the header byte.
REQ-005 SHALL have: aclk  in  1  single clock; all logic rising-edge.
REQ-006 SHALL have: aresetn  in  1  asynchronous active-low reset.
REQ-007 SHALL have: s_axis_tdata  in  NUM_SRC*DATA_WIDTH  source i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 SHALL have: s_axis_tvalid  in  NUM_SRC  per-source valid.
REQ-009 SHALL have: s_axis_tlast  in  NUM_SRC  per-source end of packet.
REQ-010 SHALL have: s_axis_tready  out  NUM_SRC  per-source ready.
REQ-011 SHALL have: m_axis_tdata  out  DATA_WIDTH  beat to UART transmitter.
REQ-012 SHALL have: m_axis_tvalid  out  1, and m_axis_tready  in  1.
REQ-013 SHALL have: grant  out  clog2(NUM_SRC)  index of the current or last owner.
REQ-014 SHALL have: busy  out  1  high while the state is not IDLE.
REQ-015 SHALL have: pkt_count  out  16  count of completed packets, wrapping.

Function
REQ-016 SHALL implement the states IDLE, HEADER and DATA.
REQ-017 IDLE: when any s_axis_tvalid is high, SHALL register the winner into grant and go to HEADER if ADD_HEADER=1, otherwise to DATA; m_axis_tvalid=0 and s_axis_tready=0 in IDLE.
REQ-018 Winner SHALL be chosen round-robin: first valid source scanning last_grant+1, last_grant+2, ... modulo NUM_SRC.
REQ-019 HEADER: SHALL drive m_axis_tvalid=1 and m_axis_tdata = zero-extended (HEADER_BASE[7:0] | grant); on m_axis_tready, go to DATA.
REQ-020 DATA: m_axis_tdata/m_axis_tvalid SHALL be combinational from source grant; s_axis_tready[grant]=m_axis_tready; all other tready bits 0.
REQ-021 DATA: a handshake with s_axis_tlast[grant]=1 SHALL return the state to IDLE, set last_grant=grant and increment pkt_count (0xFFFF wraps to 0x0000).
REQ-022 Ownership SHALL NOT change mid-packet, regardless of requests from other sources.
REQ-023 Back-to-back packets SHALL incur exactly one IDLE bubble cycle between the last beat and the next header or data beat.
REQ-024 Deassertion of s_axis_tvalid[grant] mid-packet SHALL stall the output (m_axis_tvalid=0) without releasing the grant.
REQ-025 Latency: the first output beat SHALL be valid one cycle after a request is seen in IDLE.
REQ-026 A single-beat packet (tlast on the first beat) SHALL be legal and SHALL count as one packet.
REQ-027 The m_axis output SHALL obey AXI-Stream: once valid is asserted, data stays stable until ready.

Reset
REQ-028 On aresetn=0, the state SHALL be IDLE asynchronously, regardless of any packet in progress.
REQ-029 On aresetn=0: grant=0, last_grant=NUM_SRC-1 (source 0 has first priority), pkt_count=0, busy=0.
REQ-030 On aresetn=0: m_axis_tvalid=0, m_axis_tdata=0, s_axis_tready=0.
REQ-031 A packet interrupted by reset SHALL NOT be resumed; its remaining beats SHALL be arbitrated as a new packet.

Structure
REQ-032 A shared package SHALL hold the state encoding (IDLE/HEADER/DATA) and the default HEADER_BASE constant.
REQ-033 Round-robin selection SHALL be a sub-module rr_pick (inputs req vector and last index; outputs valid flag and winner index), purely combinational.
REQ-034 The block SHALL sit between requesters and the UART transmit stream input, with no FIFO of its own.

Verification
REQ-035 Reset, then src2 sends 3 beats 0x011,0x022,0x133 (tlast on the third) -> m_axis carries the same 3 beats, grant=2, pkt_count=1, busy returns to 0.
REQ-036 src0, src1 and src3 all valid simultaneously, each with 2-beat packets -> output order src0, src1, src3, one bubble between packets, pkt_count=3.
REQ-037 src1 mid-packet while src0 asserts valid -> no src0 beat appears until src1 tlast, then src0 is granted.
REQ-038 ADD_HEADER=1, src3 1-beat packet 0x055 -> output 0x0A3 then 0x055, with tlast accepted from src3.
REQ-039 m_axis_tready toggles 1/0 every cycle during a 4-beat packet -> all beats delivered once, data held stable during stalls.
REQ-040 aresetn pulsed low after beat 2 of 4 from src1 -> outputs zeroed immediately; after release, with src0 and src1 valid, src0 is granted first.

Source files
------------

// File: rtl/axis_uart_tx_arb_pkg.sv
// Shared definitions for the AXI-Stream to UART transmit arbiter.
package axis_uart_tx_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HEADER = 2'd1,
        ST_DATA   = 2'd2
    } state_t;

    localparam logic [7:0] HEADER_BASE_DFLT = 8'hA0;

endpackage

// File: rtl/axis_uart_tx_arb_rr_pick.sv
// Combinational round-robin picker: first requester after `last`, wrapping modulo NUM_SRC.
module rr_pick #(
    parameter int NUM_SRC = 4,
    localparam int IW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [IW-1:0]      last,
    output logic               found,
    output logic [IW-1:0]      idx
);

    always_comb begin
        found = 1'b0;
        idx   = '0;
        // Scan last+1 .. last+NUM_SRC so the previous owner has lowest priority.
        for (int i = 1; i <= NUM_SRC; i++) begin
            int cand;
            cand = (int'(last) + i) % NUM_SRC;
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = IW'(cand);
            end
        end
    end

endmodule

// File: rtl/axis_uart_tx_arb.sv
// Packet-level round-robin arbiter merging NUM_SRC AXI-Stream requesters into one
// UART transmit stream, with an optional per-packet header beat carrying the source id.
module axis_uart_tx_arb
    import axis_uart_tx_arb_pkg::*;
#(
    parameter int         NUM_SRC     = 4,
    parameter int         DATA_WIDTH  = 9,
    parameter int         ADD_HEADER  = 0,
    parameter logic [7:0] HEADER_BASE = HEADER_BASE_DFLT,
    localparam int        GW          = $clog2(NUM_SRC)
) (
    input  logic                          aclk,
    input  logic                          aresetn,
    input  logic [NUM_SRC*DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [NUM_SRC-1:0]            s_axis_tvalid,
    input  logic [NUM_SRC-1:0]            s_axis_tlast,
    output logic [NUM_SRC-1:0]            s_axis_tready,
    output logic [DATA_WIDTH-1:0]         m_axis_tdata,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic [GW-1:0]                 grant,
    output logic                          busy,
    output logic [15:0]                   pkt_count
);

    state_t                state_q, state_d;
    logic [GW-1:0]         grant_q, grant_d;
    logic [GW-1:0]         last_grant_q, last_grant_d;
    logic [15:0]           pkt_count_q, pkt_count_d;

    logic                  pick_vld;
    logic [GW-1:0]         pick_idx;
    logic                  src_vld;
    logic                  src_last;
    logic [DATA_WIDTH-1:0] src_data;
    logic [7:0]            hdr_byte;

    rr_pick #(
        .NUM_SRC (NUM_SRC)
    ) u_rr_pick (
        .req   (s_axis_tvalid),
        .last  (last_grant_q),
        .found (pick_vld),
        .idx   (pick_idx)
    );

    always_comb begin
        src_vld  = s_axis_tvalid[grant_q];
        src_last = s_axis_tlast[grant_q];
        src_data = s_axis_tdata[grant_q*DATA_WIDTH +: DATA_WIDTH];
        hdr_byte = HEADER_BASE | 8'(grant_q);
    end

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        last_grant_d  = last_grant_q;
        pkt_count_d   = pkt_count_q;
        m_axis_tvalid = 1'b0;
        m_axis_tdata  = '0;
        s_axis_tready = '0;

        case (state_q)
            ST_IDLE: begin
                if (pick_vld) begin
                    grant_d = pick_idx;
                    state_d = (ADD_HEADER != 0) ? ST_HEADER : ST_DATA;
                end
            end
            ST_HEADER: begin
                m_axis_tvalid = 1'b1;
                m_axis_tdata  = DATA_WIDTH'(hdr_byte);
                if (m_axis_tready) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                // Owner stays fixed until its tlast beat is accepted.
                m_axis_tvalid          = src_vld;
                m_axis_tdata           = src_data;
                s_axis_tready[grant_q] = m_axis_tready;
                if (src_vld && m_axis_tready && src_last) begin
                    state_d      = ST_IDLE;
                    last_grant_d = grant_q;
                    pkt_count_d  = pkt_count_q + 16'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q      <= ST_IDLE;
            grant_q      <= '0;
            last_grant_q <= GW'(NUM_SRC - 1);
            pkt_count_q  <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            pkt_count_q  <= pkt_count_d;
        end
    end

    assign grant     = grant_q;
    assign busy      = (state_q != ST_IDLE);
    assign pkt_count = pkt_count_q;

endmodule

// File: tb/tb_axis_uart_tx_arb.sv
// Scoreboard bench for axis_uart_tx_arb: one instance without header, one with header.
module tb_axis_uart_tx_arb;

    localparam int N = 4;
    localparam int W = 9;

    typedef struct {
        logic [W-1:0] d;
        logic [1:0]   g;
    } exp_t;

    logic           aclk = 1'b0;
    logic           aresetn;
    always #5 aclk = ~aclk;

    // instance without header
    logic [W-1:0]   sd[N];
    logic [N-1:0]   sv, sl, s_tready;
    logic [N*W-1:0] s_tdata;
    logic [W-1:0]   m_tdata;
    logic           m_tvalid, mr, busy;
    logic [1:0]     grant;
    logic [15:0]    pkt_count;

    // instance with header
    logic [W-1:0]   hd[N];
    logic [N-1:0]   hv, hl, h_tready;
    logic [N*W-1:0] h_tdata;
    logic [W-1:0]   hm_tdata;
    logic           hm_tvalid, hmr, h_busy;
    logic [1:0]     h_grant;
    logic [15:0]    h_pkt;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            s_tdata[i*W +: W] = sd[i];
            h_tdata[i*W +: W] = hd[i];
        end
    end

    axis_uart_tx_arb #(.NUM_SRC(N), .DATA_WIDTH(W), .ADD_HEADER(0)) u_dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(sv), .s_axis_tlast(sl), .s_axis_tready(s_tready),
        .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(mr),
        .grant(grant), .busy(busy), .pkt_count(pkt_count)
    );

    axis_uart_tx_arb #(.NUM_SRC(N), .DATA_WIDTH(W), .ADD_HEADER(1)) u_hdr (
        .aclk(aclk), .aresetn(aresetn),
        .s_axis_tdata(h_tdata), .s_axis_tvalid(hv), .s_axis_tlast(hl), .s_axis_tready(h_tready),
        .m_axis_tdata(hm_tdata), .m_axis_tvalid(hm_tvalid), .m_axis_tready(hmr),
        .grant(h_grant), .busy(h_busy), .pkt_count(h_pkt)
    );

    int   pass_cnt = 0;
    int   total_cnt = 0;
    int   cyc = 0;
    int   cyc_log[$];
    exp_t q0[$], q1[$];
    logic         prev_stall = 1'b0;
    logic [W-1:0] prev_data = '0;

    always @(posedge aclk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    endtask

    // Monitor: compares every accepted output beat against the scoreboard.
    always @(negedge aclk) begin
        if (!aresetn) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("hold_valid", {31'd0, m_tvalid}, 32'd1);
                chk("hold_data", {23'd0, m_tdata}, {23'd0, prev_data});
            end
            prev_stall = m_tvalid && !mr;
            prev_data  = m_tdata;
            if (m_tvalid && mr) begin
                cyc_log.push_back(cyc);
                if (q0.size() == 0) begin
                    total_cnt++;
                    $display("FAIL extra_beat: got 0x%0h, expected no beat", m_tdata);
                end else begin
                    exp_t e;
                    e = q0.pop_front();
                    chk("beat_data", {23'd0, m_tdata}, {23'd0, e.d});
                    chk("beat_grant", {30'd0, grant}, {30'd0, e.g});
                end
            end
            if (hm_tvalid && hmr) begin
                if (q1.size() == 0) begin
                    total_cnt++;
                    $display("FAIL hdr_extra_beat: got 0x%0h, expected no beat", hm_tdata);
                end else begin
                    exp_t e;
                    e = q1.pop_front();
                    chk("hdr_beat_data", {23'd0, hm_tdata}, {23'd0, e.d});
                    chk("hdr_beat_grant", {30'd0, h_grant}, {30'd0, e.g});
                end
            end
        end
    end

    task automatic push0(input logic [W-1:0] d, input logic [1:0] g);
        exp_t e;
        e.d = d; e.g = g;
        q0.push_back(e);
    endtask

    task automatic push1(input logic [W-1:0] d, input logic [1:0] g);
        exp_t e;
        e.d = d; e.g = g;
        q1.push_back(e);
    endtask

    // Wait for the current beat of source s on instance dut to be accepted.
    task automatic wait_hs(input int dut, input int s);
        int  k;
        bit  done;
        k = 0;
        done = 1'b0;
        while (!done) begin
            @(negedge aclk);
            done = (dut == 0) ? (sv[s] && s_tready[s]) : (hv[s] && h_tready[s]);
            @(posedge aclk);
            #1;
            k++;
            if (k > 200) begin
                $display("FAIL handshake_timeout: dut %0d src %0d got no ready, expected ready within 200 cycles", dut, s);
                $fatal(1, "handshake timeout");
            end
        end
    endtask

    task automatic send_pkt(input int dut, input int s, input int n, input logic [4*W-1:0] pk);
        for (int i = 0; i < n; i++) begin
            if (dut == 0) begin
                sd[s] = pk[i*W +: W]; sv[s] = 1'b1; sl[s] = (i == n - 1);
            end else begin
                hd[s] = pk[i*W +: W]; hv[s] = 1'b1; hl[s] = (i == n - 1);
            end
            wait_hs(dut, s);
        end
        if (dut == 0) begin
            sv[s] = 1'b0; sl[s] = 1'b0;
        end else begin
            hv[s] = 1'b0; hl[s] = 1'b0;
        end
    endtask

    task automatic pulse_reset();
        aresetn = 1'b0;
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
    endtask

    initial begin
        int  c0;
        bit  tog_en;
        aresetn = 1'b0;
        sv = '0; sl = '0; hv = '0; hl = '0;
        mr = 1'b1; hmr = 1'b1;
        for (int i = 0; i < N; i++) begin
            sd[i] = '0; hd[i] = '0;
        end
        repeat (2) @(posedge aclk);
        #1;
        chk("rst_tvalid", {31'd0, m_tvalid}, 32'd0);
        chk("rst_tdata", {23'd0, m_tdata}, 32'd0);
        chk("rst_tready", {28'd0, s_tready}, 32'd0);
        chk("rst_grant", {30'd0, grant}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_pkt_count", {16'd0, pkt_count}, 32'd0);
        aresetn = 1'b1;
        @(posedge aclk);
        #1;

        // single 3-beat packet from src2
        cyc_log.delete();
        push0(9'h011, 2); push0(9'h022, 2); push0(9'h133, 2);
        c0 = cyc;
        send_pkt(0, 2, 3, {9'h000, 9'h133, 9'h022, 9'h011});
        chk("t1_latency", cyc_log[0] - c0, 32'd1);
        chk("t1_busy", {31'd0, busy}, 32'd0);
        chk("t1_grant", {30'd0, grant}, 32'd2);
        chk("t1_pkt_count", {16'd0, pkt_count}, 32'd1);

        // src0, src1, src3 contend from reset priority
        pulse_reset();
        cyc_log.delete();
        push0(9'h001, 0); push0(9'h102, 0);
        push0(9'h011, 1); push0(9'h112, 1);
        push0(9'h031, 3); push0(9'h132, 3);
        fork
            send_pkt(0, 0, 2, {9'h000, 9'h000, 9'h102, 9'h001});
            send_pkt(0, 1, 2, {9'h000, 9'h000, 9'h112, 9'h011});
            send_pkt(0, 3, 2, {9'h000, 9'h000, 9'h132, 9'h031});
        join
        chk("t2_beats", cyc_log.size(), 32'd6);
        if (cyc_log.size() == 6) begin
            chk("t2_inpkt_gap", cyc_log[1] - cyc_log[0], 32'd1);
            chk("t2_bubble_a", cyc_log[2] - cyc_log[1], 32'd2);
            chk("t2_bubble_b", cyc_log[4] - cyc_log[3], 32'd2);
        end
        chk("t2_pkt_count", {16'd0, pkt_count}, 32'd3);

        // src1 owns the stream (with a valid gap) while src0 requests
        push0(9'h041, 1); push0(9'h042, 1); push0(9'h143, 1);
        push0(9'h051, 0); push0(9'h152, 0);
        fork
            begin
                sd[1] = 9'h041; sv[1] = 1'b1; sl[1] = 1'b0;
                wait_hs(0, 1);
                sv[1] = 1'b0;
                repeat (3) begin
                    @(negedge aclk);
                    chk("t3_stall_valid", {31'd0, m_tvalid}, 32'd0);
                    chk("t3_stall_grant", {30'd0, grant}, 32'd1);
                    @(posedge aclk);
                    #1;
                end
                sd[1] = 9'h042; sv[1] = 1'b1;
                wait_hs(0, 1);
                sd[1] = 9'h143; sl[1] = 1'b1;
                wait_hs(0, 1);
                sv[1] = 1'b0; sl[1] = 1'b0;
            end
            begin
                @(posedge aclk);
                #1;
                send_pkt(0, 0, 2, {9'h000, 9'h000, 9'h152, 9'h051});
            end
        join
        chk("t3_pkt_count", {16'd0, pkt_count}, 32'd5);

        // m_axis_tready toggling during a 4-beat packet from src2
        push0(9'h081, 2); push0(9'h082, 2); push0(9'h083, 2); push0(9'h184, 2);
        tog_en = 1'b1;
        fork
            begin
                send_pkt(0, 2, 4, {9'h184, 9'h083, 9'h082, 9'h081});
                tog_en = 1'b0;
            end
            begin
                while (tog_en) begin
                    @(posedge aclk);
                    #1;
                    mr = ~mr;
                end
            end
        join
        mr = 1'b1;
        chk("t4_pkt_count", {16'd0, pkt_count}, 32'd6);

        // reset in the middle of a src1 packet
        push0(9'h061, 1); push0(9'h062, 1);
        sd[1] = 9'h061; sv[1] = 1'b1; sl[1] = 1'b0;
        wait_hs(0, 1);
        sd[1] = 9'h062;
        wait_hs(0, 1);
        sd[1] = 9'h063;
        sd[0] = 9'h171; sv[0] = 1'b1; sl[0] = 1'b1;
        aresetn = 1'b0;
        #1;
        chk("t5_rst_tvalid", {31'd0, m_tvalid}, 32'd0);
        chk("t5_rst_tdata", {23'd0, m_tdata}, 32'd0);
        chk("t5_rst_tready", {28'd0, s_tready}, 32'd0);
        chk("t5_rst_busy", {31'd0, busy}, 32'd0);
        chk("t5_rst_grant", {30'd0, grant}, 32'd0);
        chk("t5_rst_pkt_count", {16'd0, pkt_count}, 32'd0);
        push0(9'h171, 0); push0(9'h063, 1); push0(9'h164, 1);
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
        fork
            begin
                wait_hs(0, 0);
                sv[0] = 1'b0; sl[0] = 1'b0;
            end
            begin
                wait_hs(0, 1);
                sd[1] = 9'h164; sl[1] = 1'b1;
                wait_hs(0, 1);
                sv[1] = 1'b0; sl[1] = 1'b0;
            end
        join
        chk("t5_pkt_count", {16'd0, pkt_count}, 32'd2);

        // header mode: single-beat packet from src3
        push1(9'h0A3, 3); push1(9'h055, 3);
        hd[3] = 9'h055; hv[3] = 1'b1; hl[3] = 1'b1;
        wait_hs(1, 3);
        hv[3] = 1'b0; hl[3] = 1'b0;
        chk("t6_pkt_count", {16'd0, h_pkt}, 32'd1);
        chk("t6_busy", {31'd0, h_busy}, 32'd0);

        repeat (3) @(posedge aclk);
        #1;
        chk("sb0_empty", q0.size(), 32'd0);
        chk("sb1_empty", q1.size(), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
